// File: rtl/shift_ser_ctrl.sv
// shift_ser_ctrl: valid/ready word intake feeding a parallel-in serial-out
// shifter with a programmable bit period (div+1 cycles per bit).
// Optional parity bit after the data bits: define SHIFT_SER_CTRL_PARITY_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a word; s_ready=1, line at IDLE_LVL
// ST_SHIFT | frame on the line; baud counter paces each bit
// ST_DONE  | single cycle after the last bit; done pulse, line at IDLE_LVL

module shift_ser_ctrl #(
   parameter int WIDTH     = 8,
   parameter int DIV_W     = 16,
   parameter bit MSB_FIRST = 1'b0,
   parameter bit IDLE_LVL  = 1'b1,
`ifdef SHIFT_SER_CTRL_PARITY_EN
   localparam int IDX_W    = $clog2(WIDTH + 1)
`else
   localparam int IDX_W    = $clog2(WIDTH)
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic [DIV_W-1:0] div,
   input  logic             abort,
`ifdef SHIFT_SER_CTRL_PARITY_EN
   input  logic             parity_odd,
`endif
   output logic             serial_out,
   output logic             bit_stb,
   output logic [IDX_W-1:0] bit_idx,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
`ifdef SHIFT_SER_CTRL_PARITY_EN
   localparam logic [IDX_W-1:0] PAR_IDX  = IDX_W'(WIDTH);
`endif

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               ser_q, ser_d;
   logic               stb_q, stb_d;
   logic               done_q, done_d;
`ifdef SHIFT_SER_CTRL_PARITY_EN
   logic               par_q, par_d;
`endif

   // Advance the shift register by one bit toward the output end.
   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      if (MSB_FIRST) r = {v[WIDTH-2:0], 1'b0};
      else           r = {1'b0, v[WIDTH-1:1]};
      return r;
   endfunction

   // The bit that goes on the line next is always at the output end.
   function automatic logic head(input logic [WIDTH-1:0] v);
      logic r;
      if (MSB_FIRST) r = v[WIDTH-1];
      else           r = v[0];
      return r;
   endfunction

   // Next-state and registered-output decode; abort outranks every SHIFT move.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      ser_d   = ser_q;
      stb_d   = 1'b0;
      done_d  = 1'b0;
`ifdef SHIFT_SER_CTRL_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            ser_d = IDLE_LVL;
            if (s_valid) begin
               // Word and period are captured here; later input changes
               // cannot disturb the frame.
               sr_d    = s_data;
               div_d   = div;
               cnt_d   = div;
               idx_d   = '0;
               ser_d   = head(s_data);
               stb_d   = 1'b1;
               state_d = ST_SHIFT;
`ifdef SHIFT_SER_CTRL_PARITY_EN
               par_d   = (^s_data) ^ parity_odd;
`endif
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_IDLE;
               ser_d   = IDLE_LVL;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (idx_q < LAST_IDX) begin
               sr_d  = shift_once(sr_q);
               ser_d = head(shift_once(sr_q));
               idx_d = idx_q + 1'b1;
               cnt_d = div_q;
               stb_d = 1'b1;
`ifdef SHIFT_SER_CTRL_PARITY_EN
            end else if (idx_q == LAST_IDX) begin
               ser_d = par_q;
               idx_d = PAR_IDX;
               cnt_d = div_q;
               stb_d = 1'b1;
`endif
            end else begin
               state_d = ST_DONE;
               ser_d   = IDLE_LVL;
               idx_d   = '0;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            ser_d   = IDLE_LVL;
            idx_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            ser_d   = IDLE_LVL;
            idx_d   = '0;
         end
      endcase
   end

   // State and datapath registers; reset forces the line idle and drops the frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         ser_q   <= IDLE_LVL;
         stb_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef SHIFT_SER_CTRL_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         ser_q   <= ser_d;
         stb_q   <= stb_d;
         done_q  <= done_d;
`ifdef SHIFT_SER_CTRL_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign s_ready    = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign serial_out = ser_q;
   assign bit_stb    = stb_q;
   assign bit_idx    = idx_q;
   assign done       = done_q;

endmodule
